// File: rtl/seq_stage_controller.sv
// Multi-cycle stage sequencer for the SEQ Y86-64 datapath: one-hot stage strobes,
// data-memory handshake with timeout, status code and retired-instruction count.
module seq_stage_controller #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic        instr_valid,
  input  logic        imem_error,
  input  logic        dmem_ready,
  input  logic        dmem_error,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        execute_en,
  output logic        memory_en,
  output logic        writeback_en,
  output logic        pc_en,
  output logic        dmem_req,
  output logic        busy,
  output logic [2:0]  stat,
  output logic [31:0] instr_count
);
  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] HLT = 3'd2;
  localparam logic [2:0] ADR = 3'd3;
  localparam logic [2:0] INS = 3'd4;
  // Last wait-count value before timeout; counter is 0 on the first MEMORY cycle.
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPDATE, HALTED
  } state_t;

  state_t     state, state_d;
  logic [2:0] stat_d;
  logic [3:0] icode_q;
  logic [7:0] wait_cnt;
  logic       mem_op;
  logic       launch;

  assign mem_op = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  assign launch = (state == IDLE || state == HALTED) && start;

  always_comb begin
    state_d = state;
    stat_d  = stat;
    case (state)
      IDLE, HALTED: if (start) begin state_d = FETCH; stat_d = AOK; end
      FETCH: begin
        if (imem_error) begin
          state_d = HALTED; stat_d = ADR;
        end else if (!instr_valid || icode > 4'hB) begin
          state_d = HALTED; stat_d = INS;
        end else if (icode == 4'h0) begin
          state_d = HALTED; stat_d = HLT;
        end else begin
          state_d = DECODE;
        end
      end
      DECODE:    state_d = EXECUTE;
      EXECUTE:   state_d = mem_op ? MEMORY : WRITEBACK;
      MEMORY: begin
        // ready takes precedence over a timeout on the same edge
        if (dmem_ready) begin
          if (dmem_error) begin state_d = HALTED; stat_d = ADR; end
          else            state_d = WRITEBACK;
        end else if (wait_cnt == TO_LAST) begin
          state_d = HALTED; stat_d = ADR;
        end
      end
      WRITEBACK: state_d = PCUPDATE;
      PCUPDATE:  state_d = FETCH;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      stat        <= AOK;
      icode_q     <= 4'h0;
      wait_cnt    <= 8'd0;
      instr_count <= 32'd0;
    end else begin
      state <= state_d;
      stat  <= stat_d;
      if (state == FETCH) icode_q <= icode;
      if (state != MEMORY)  wait_cnt <= 8'd0;
      else if (!dmem_ready) wait_cnt <= wait_cnt + 8'd1;
      if (launch)                 instr_count <= 32'd0;
      else if (state == PCUPDATE) instr_count <= instr_count + 32'd1;
    end
  end

  assign fetch_en     = (state == FETCH);
  assign decode_en    = (state == DECODE);
  assign execute_en   = (state == EXECUTE);
  assign memory_en    = (state == MEMORY);
  assign writeback_en = (state == WRITEBACK);
  assign pc_en        = (state == PCUPDATE);
  assign dmem_req     = memory_en;
  assign busy         = (state != IDLE) && (state != HALTED);
endmodule
